// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative 32-bit MULTU/MULT/DIVU/DIV unit, one shift-add or restoring-subtract step per cycle.
// Define MULDIV_EARLY_OUT_EN to skip the iteration phase when either operand is zero.
module iter_muldiv #(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] hi_o,
    output logic [N-1:0] lo_o,
    output logic         div_by_zero_o
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3;
    localparam int CW = $clog2(N) + 1;
    logic [1:0]     state_q, state_d, op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   a_q, a_d, bm_q, bm_d, sr_q, sr_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*N-1:0] acc_q, acc_d, prod;
    logic           neg_q, neg_d, rneg_q, rneg_d, zb_q, zb_d, dz_q, dz_d;
    logic           accept, sa, sb, borrow;
    logic [N-1:0]   amag, bmag, q, r;
    logic [N:0]     msum, dsh;
    logic [N+1:0]   ddiff;
    always_comb begin
        sa = op_i[0] & a_i[N-1];
        sb = op_i[0] & b_i[N-1];
        amag = sa ? -a_i : a_i;
        bmag = sb ? -b_i : b_i;
        accept = start_i && (state_q == IDLE || state_q == DONE);
        msum = {1'b0, acc_q[2*N-1:N]} + {1'b0, sr_q[0] ? bm_q : '0};
        dsh = {acc_q[N-1:0], sr_q[N-1]};
        ddiff = {1'b0, dsh} - {2'b0, bm_q};
        borrow = ddiff[N+1];
        prod = neg_q ? -acc_q : acc_q;
        q = neg_q ? -sr_q : sr_q;
        r = rneg_q ? -acc_q[N-1:0] : acc_q[N-1:0];
        state_d = state_q;
        cnt_d = cnt_q;
        op_d = op_q;
        a_d = a_q;
        bm_d = bm_q;
        sr_d = sr_q;
        acc_d = acc_q;
        neg_d = neg_q;
        rneg_d = rneg_q;
        zb_d = zb_q;
        hi_d = hi_q;
        lo_d = lo_q;
        dz_d = dz_q;
        if (accept) begin
            op_d = op_i;
            a_d = a_i;
            cnt_d = '0;
            acc_d = '0;
            neg_d = sa ^ sb;
            rneg_d = sa;
            zb_d = op_i[1] && b_i == '0;
            // Divide shifts the dividend through sr; multiply shifts the multiplier.
            bm_d = op_i[1] ? bmag : amag;
            sr_d = op_i[1] ? amag : bmag;
`ifdef MULDIV_EARLY_OUT_EN
            state_d = (a_i == '0 || b_i == '0) ? FIX : RUN;
`else
            state_d = RUN;
`endif
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = op_q[1] ? {{(N-1){1'b0}}, borrow ? dsh : ddiff[N:0]} : {msum, acc_q[N-1:1]};
            sr_d = op_q[1] ? {sr_q[N-2:0], ~borrow} : sr_q >> 1;
            state_d = cnt_q == CW'(N - 1) ? FIX : RUN;
        end else if (state_q == FIX) begin
            hi_d = op_q[1] ? (zb_q ? a_q : r) : prod[2*N-1:N];
            lo_d = op_q[1] ? (zb_q ? '1 : q) : prod[N-1:0];
            dz_d = zb_q;
            state_d = DONE;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q <= '0;
            op_q <= '0;
            a_q <= '0;
            bm_q <= '0;
            sr_q <= '0;
            acc_q <= '0;
            neg_q <= 1'b0;
            rneg_q <= 1'b0;
            zb_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
            dz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            op_q <= op_d;
            a_q <= a_d;
            bm_q <= bm_d;
            sr_q <= sr_d;
            acc_q <= acc_d;
            neg_q <= neg_d;
            rneg_q <= rneg_d;
            zb_q <= zb_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            dz_q <= dz_d;
        end
    end
    assign busy_o = state_q == RUN || state_q == FIX;
    assign done_o = state_q == DONE;
    assign hi_o = hi_q;
    assign lo_o = lo_q;
    assign div_by_zero_o = dz_q;
endmodule

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
- Iterative 32-bit multiply/divide unit for the multi-cycle datapath.
- Sits directly upstream of the HI/LO result registers (n-bit enabled, synchronously reset registers). Its `done` pulse drives their `en`; its `hi`/`lo` outputs drive their `d` inputs.
- Performs one shift-add or restore-subtract step per cycle, under a start/busy/done handshake with the control unit.

Parameters:
- N, 32, operand width; `hi`/`lo` are each N bits; iteration count = N.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- op  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed); latched on accept
- a  input  N  multiplicand / dividend; latched on accept
- b  input  N  multiplier / divisor; latched on accept
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; hi/lo/div_by_zero valid
- hi  output  N  product upper half / remainder
- lo  output  N  product lower half / quotient
- div_by_zero  output  1  set with done when a divide had b==0

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, iteration counter=0. An in-flight operation is abandoned, with no done pulse.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1; N iterations.
  - FIX: busy=1; sign correction and result selection.
  - DONE: busy=0, done=1.
- Transitions:
  - IDLE/DONE with start=1 → RUN. This is the accept edge: latch op/a/b, clear the counter. For signed ops, convert operands to magnitudes and record the result signs.
  - IDLE with start=0 → IDLE.
  - DONE with start=0 → IDLE.
  - RUN: counter increments each edge; after the N-th iteration edge → FIX.
  - FIX → DONE; hi/lo/div_by_zero are registered on this edge.
- Latency: done=1 in the cycle following edge N+1 after the accept edge. That is, N+2 cycles from the accept cycle to the done cycle (34 for N=32).
- Back-to-back: start=1 in the DONE cycle is accepted, so the next RUN begins directly.
- start while busy=1: ignored, not queued. Changes on op/a/b while busy have no effect.
- hi/lo/div_by_zero hold their values from the FIX edge until the next FIX edge or reset. They change only at FIX.
- Multiply: {hi,lo} = full 2N-bit product. MULT is two's-complement signed; MULTU is unsigned.
- Divide: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - Signed overflow: 0x80000000 / -1 gives lo=0x80000000, hi=0, with no flag.
- Divide with b==0 (DIVU or DIV): lo = all ones, hi = a (original, unmodified), div_by_zero=1.
  - Latency is unchanged.
  - div_by_zero=0 for all multiplies and non-zero divides.
- Internal datapath: 2N-bit accumulator/remainder plus an N-bit shift register. Operand magnitudes are N-bit unsigned, so 0x80000000 is handled as 2^31.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN
- Defined: if, at accept, a==0 or b==0, the unit skips RUN and goes from the accept edge straight to FIX. done is then asserted 2 cycles after the accept cycle. Results are identical to the full path:
  - multiply → 0,0;
  - divide with a==0, b!=0 → lo=0, hi=0;
  - divide with b==0 → the div_by_zero result defined above.
- Undefined: latency is always N+2 cycles regardless of operand values.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the accept cycle; busy high through RUN/FIX.
- MULT a=0xFFFFFFFD (-3) b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT a=0x80000000 b=0x80000000 → hi=0x40000000, lo=0.
- DIVU a=100 b=7 → lo=14, hi=2. DIV a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
- DIVU a=0x12345678 b=0 → lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1. A following MULTU 2*3 → hi=0, lo=6, div_by_zero=0.
- Assert reset asynchronously (mid-cycle, between clock edges) during RUN at iteration 10 → busy, done, hi, lo and div_by_zero all read 0 before the next clock edge. Release reset, then issue DIVU 9/3 → lo=3, hi=0 with normal latency.
- start held high during a whole RUN with changing a/b → the second operation is accepted only in the DONE cycle. The first result comes from the operands latched at the first accept. The second done arrives 34 cycles after the DONE cycle.
- With MULDIV_EARLY_OUT_EN: MULT a=0 b=5 → done 2 cycles after accept, hi=lo=0.
